// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver for an HH:MM clock display.
// Frame-coherent shadowed digits, PWM dimming, leading-zero blank and a blinking colon.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       userclock,
  input  logic       rst_n,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic       sec_tick,
  input  logic       blank_lz,
  input  logic       colon_en,
  input  logic [1:0] dim,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned QTR   = REFRESH_DIV / 4;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W:0]   LIM_0  = (CNT_W+1)'(QTR);
  localparam logic [CNT_W:0]   LIM_1  = (CNT_W+1)'(2 * QTR);
  localparam logic [CNT_W:0]   LIM_2  = (CNT_W+1)'(3 * QTR);
  localparam logic [CNT_W:0]   LIM_3  = (CNT_W+1)'(REFRESH_DIV);

  logic [CNT_W-1:0]       cnt;
  logic [1:0]             idx;
  logic [3:0][3:0]        shadow;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sec_d;
  logic                   colon_ph;

  logic                   tc;
  logic                   sec_rise;
  logic [3:0]             cur;
  logic [6:0]             dec;
  logic [CNT_W:0]         lim;
  logic                   on_win;
  logic                   blank;
  logic [3:0]             an_nxt;
  logic [6:0]             seg_nxt;
  logic                   dp_nxt;

  // Slot timing, digit selection and output decode from the current cnt/idx
  always_comb begin
    tc       = (cnt == CNT_TC);
    sec_rise = sync_q[SYNC_STAGES-1] & ~sec_d;
    cur      = shadow[idx];
    dec      = 7'b0111111;
    lim      = LIM_3;
    an_nxt   = 4'b1111;
    seg_nxt  = 7'b1111111;
    dp_nxt   = 1'b1;

    unique case (cur)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase

    unique case (dim)
      2'd0:    lim = LIM_0;
      2'd1:    lim = LIM_1;
      2'd2:    lim = LIM_2;
      default: lim = LIM_3;
    endcase

    on_win = ({1'b0, cnt} < lim);
    blank  = (idx == 2'd3) && blank_lz && (cur == 4'd0);

    if (on_win && !blank) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = dec;
    end
    if (on_win && (idx == 2'd2) && colon_en && colon_ph) begin
      dp_nxt = 1'b0;
    end
  end

  // Prescaler, digit index and shadow capture at the end of each frame
  always_ff @(posedge userclock or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= 2'd0;
      shadow <= '0;
    end else begin
      if (tc) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          shadow <= {num3, num2, num1, num0};
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // sec_tick synchronizer, rising-edge detect and colon phase
  always_ff @(posedge userclock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      sec_d    <= 1'b0;
      colon_ph <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sec_tick};
      sec_d  <= sync_q[SYNC_STAGES-1];
      if (sec_rise) begin
        colon_ph <= ~colon_ph;
      end
    end
  end

  // Registered display outputs, dark while in reset
  always_ff @(posedge userclock or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with a small frame-position reference model
// plus directed checks on scan order, tearing, dimming, blanking, colon and reset.
module tb_seg7_scan;

  localparam int DIV   = 8;
  localparam int SYNC  = 2;
  localparam int FRAME = 4 * DIV;

  logic       userclock = 1'b0;
  logic       rst_n     = 1'b0;
  logic [3:0] num0 = 4'd0, num1 = 4'd0, num2 = 4'd0, num3 = 4'd0;
  logic       sec_tick = 1'b0;
  logic       blank_lz = 1'b0;
  logic       colon_en = 1'b0;
  logic [1:0] dim      = 2'd3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan #(.REFRESH_DIV(DIV), .SYNC_STAGES(SYNC)) dut (
    .userclock(userclock), .rst_n(rst_n),
    .num0(num0), .num1(num1), .num2(num2), .num3(num3),
    .sec_tick(sec_tick), .blank_lz(blank_lz), .colon_en(colon_en), .dim(dim),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 userclock = ~userclock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within a 32-cycle frame, table decode, duty table
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  int duty [4] = '{DIV / 4, DIV / 2, 3 * DIV / 4, DIV};

  logic [11:0] exp_q [$];
  int          m_pos     = 0;
  int          shown_pos = -1;
  logic [3:0]  m_sh [4]  = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic        m_ph      = 1'b0;
  logic [3:0]  m_samp    = 4'd0;
  int          m_c, m_i;
  logic        m_on;
  logic [11:0] m_e;

  always @(posedge userclock or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; shown_pos = -1; m_ph = 1'b0; m_samp = 4'd0;
      for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
      exp_q.delete();
    end else begin
      m_c  = m_pos % DIV;
      m_i  = m_pos / DIV;
      m_on = (m_c < duty[dim]);
      m_e  = 12'hFFF;
      if (m_on && !(m_i == 3 && blank_lz && m_sh[3] == 4'd0)) begin
        m_e[11:8] = ~(4'(4'b0001 << m_i));
        m_e[7:1]  = seg_tab[m_sh[m_i]];
      end
      if (m_on && m_i == 2 && colon_en && m_ph) m_e[0] = 1'b0;
      exp_q.push_back(m_e);
      shown_pos = m_pos;
      if (m_samp[SYNC-1] && !m_samp[SYNC]) m_ph = ~m_ph;
      m_samp = {m_samp[2:0], sec_tick};
      if (m_pos == FRAME - 1) begin
        m_sh[0] = num0; m_sh[1] = num1; m_sh[2] = num2; m_sh[3] = num3;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  end

  always @(negedge userclock) begin
    if (!rst_n) begin
      check("reset_out", {an, seg, dp}, 12'hFFF);
    end else if (exp_q.size() > 0) begin
      check("scan", {an, seg, dp}, exp_q.pop_front());
      check("onehot", 12'($countones(~an) <= 1), 12'd1);
    end
  end

  task automatic wait_pos(input int p);
    int budget;
    budget = 4 * FRAME;
    @(negedge userclock);
    while (shown_pos != p && budget > 0) begin
      @(negedge userclock);
      budget--;
    end
    if (budget == 0) check("wait_timeout", 12'd0, 12'd1);
  endtask

  task automatic check_slot(input string tag, input int d, input logic [3:0] e_an, input logic [6:0] e_seg);
    wait_pos(d * DIV);
    check(tag, {1'b0, an, seg}, {1'b0, e_an, e_seg});
  endtask

  task automatic count_on(input int d, output int n);
    wait_pos(d * DIV);
    n = 0;
    repeat (DIV) begin
      if (an != 4'b1111) n++;
      @(negedge userclock);
    end
  endtask

  task automatic count_dp(output int n);
    wait_pos(0);
    n = 0;
    repeat (FRAME) begin
      if (dp == 1'b0) n++;
      @(negedge userclock);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge userclock);
    check("reset_state", {an, seg, dp}, 12'hFFF);
    num3 = 4'd3; num2 = 4'd2; num1 = 4'd1; num0 = 4'd0;
    @(negedge userclock);
    rst_n = 1'b1;

    // First frame still shows zeroed shadows
    check_slot("first_frame_d1", 1, 4'b1101, 7'b1000000);
    check_slot("scan_d0", 0, 4'b1110, 7'b1000000);
    check_slot("scan_d1", 1, 4'b1101, 7'b1111001);
    check_slot("scan_d2", 2, 4'b1011, 7'b0100100);
    check_slot("scan_d3", 3, 4'b0111, 7'b0110000);

    // Tearing: mid-frame changes wait for the next frame
    num0 = 4'd5;
    check_slot("d0_five", 0, 4'b1110, 7'b0010010);
    wait_pos(DIV);
    num0 = 4'd6; num2 = 4'd7;
    check_slot("tear_d2_old", 2, 4'b1011, 7'b0100100);
    check_slot("tear_d0_new", 0, 4'b1110, 7'b0000010);
    check_slot("tear_d2_new", 2, 4'b1011, 7'b1111000);

    // Dimming duty per slot
    dim = 2'd0; count_on(1, n); check("dim0_on", 12'(n), 12'd2);
    dim = 2'd2; count_on(0, n); check("dim2_on", 12'(n), 12'd6);
    dim = 2'd1; count_on(2, n); check("dim1_on", 12'(n), 12'd4);
    dim = 2'd3; count_on(3, n); check("dim3_on", 12'(n), 12'd8);

    // Leading-zero blank
    num3 = 4'd0; blank_lz = 1'b1;
    wait_pos(FRAME - 1);
    count_on(3, n); check("lz_blank", 12'(n), 12'd0);
    check_slot("lz_d0_kept", 0, 4'b1110, 7'b0000010);
    count_on(2, n); check("lz_d2_kept", 12'(n), 12'd8);
    blank_lz = 1'b0;
    count_on(3, n); check("lz_off", 12'(n), 12'd8);

    // Colon blinking on sec_tick rising edges
    colon_en = 1'b1;
    count_dp(n); check("colon_before", 12'(n), 12'd0);
    sec_tick = 1'b1; repeat (4) @(negedge userclock);
    count_dp(n); check("colon_edge1", 12'(n), 12'(DIV));
    sec_tick = 1'b0; repeat (4) @(negedge userclock);
    sec_tick = 1'b1; repeat (4) @(negedge userclock);
    count_dp(n); check("colon_edge2", 12'(n), 12'd0);
    sec_tick = 1'b0; repeat (4) @(negedge userclock);
    sec_tick = 1'b1; colon_en = 1'b0; repeat (4) @(negedge userclock);
    count_dp(n); check("colon_dis", 12'(n), 12'd0);

    // Mid-slot asynchronous reset at cnt=5, idx=2
    wait_pos(2 * DIV + 4);
    @(posedge userclock);
    #1;
    check("pre_rst_active", {8'd0, an}, 12'b0000_0000_1011);
    #1 rst_n = 1'b0;
    #1 check("async_rst", {an, seg, dp}, 12'hFFF);
    repeat (2) @(negedge userclock);
    rst_n = 1'b1;
    @(negedge userclock);
    check("post_rst_first", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});

    repeat (2 * FRAME) @(negedge userclock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
